// File: rtl/countdown_ctrl_if.sv
// Control/data bundle between the button and rate-divider logic and the countdown sequencer.
interface countdown_ctrl_if;
  logic        tick;
  logic        start;
  logic        pause;
  logic        clear;
  logic [15:0] preset;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic [2:0]  state;

  modport master (
    output tick, start, pause, clear, preset,
    input  digits, running, done, state
  );

  modport slave (
    input  tick, start, pause, clear, preset,
    output digits, running, done, state
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Four-digit BCD MM:SS countdown sequencer with start/pause/resume/clear and expiry flag.
// Optional macro COUNTDOWN_AUTORELOAD_EN: on expiry, reload the preset and keep running.
module countdown_ctrl #(
  parameter int PRESCALE     = 1,
  parameter int MIN_TENS_MAX = 9
) (
  input  logic             clock,
  input  logic             reset,
  countdown_ctrl_if.slave  bus
);

  localparam logic [2:0]  S_IDLE    = 3'd0;
  localparam logic [2:0]  S_RUN     = 3'd1;
  localparam logic [2:0]  S_PAUSE   = 3'd2;
  localparam logic [2:0]  S_EXPIRED = 3'd3;
  localparam logic [7:0]  PS_LAST   = 8'(PRESCALE - 1);
  localparam logic [15:0] DIGIT_MAX = {4'(MIN_TENS_MAX), 4'd9, 4'd5, 4'd9};

  logic [2:0]  state_reg, state_next;
  logic [15:0] digits_reg, digits_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        running_reg;
  logic        done_reg;
  logic        expire_evt_reg, expire_evt_next;

  logic [15:0] preset_clamped;
  logic [15:0] digits_dec;
  logic        borrow_so, borrow_st, borrow_mo;

  // Each preset digit saturates at its own ceiling.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_clamp
      assign preset_clamped[gi*4 +: 4] =
        (bus.preset[gi*4 +: 4] > DIGIT_MAX[gi*4 +: 4]) ? DIGIT_MAX[gi*4 +: 4]
                                                        : bus.preset[gi*4 +: 4];
    end
  endgenerate

  // One-second decrement with mod-10 / mod-6 borrow chaining.
  assign borrow_so = (digits_reg[3:0] == 4'd0);
  assign borrow_st = borrow_so && (digits_reg[7:4] == 4'd0);
  assign borrow_mo = borrow_st && (digits_reg[11:8] == 4'd0);

  always_comb begin
    digits_dec[3:0]   = borrow_so ? 4'd9 : digits_reg[3:0] - 4'd1;
    digits_dec[7:4]   = digits_reg[7:4];
    digits_dec[11:8]  = digits_reg[11:8];
    digits_dec[15:12] = digits_reg[15:12];
    if (borrow_so)
      digits_dec[7:4] = (digits_reg[7:4] == 4'd0) ? 4'd5 : digits_reg[7:4] - 4'd1;
    if (borrow_st)
      digits_dec[11:8] = (digits_reg[11:8] == 4'd0) ? 4'd9 : digits_reg[11:8] - 4'd1;
    if (borrow_mo)
      digits_dec[15:12] = digits_reg[15:12] - 4'd1;
  end

  always_comb begin
    state_next      = state_reg;
    digits_next     = digits_reg;
    cnt_next        = cnt_reg;
    expire_evt_next = 1'b0;
    if (bus.clear) begin
      state_next  = S_IDLE;
      digits_next = preset_clamped;
      cnt_next    = 8'd0;
    end else begin
      case (state_reg)
        S_IDLE, S_EXPIRED: begin
          if (state_reg == S_IDLE)
            digits_next = preset_clamped;
          if (bus.start) begin
            cnt_next = 8'd0;
            // A zero preset has nothing to count, so it expires on the load edge.
            if (preset_clamped == 16'h0000) begin
              state_next      = S_EXPIRED;
              digits_next     = 16'h0000;
              expire_evt_next = 1'b1;
            end else begin
              state_next  = S_RUN;
              digits_next = preset_clamped;
            end
          end
        end
        S_RUN: begin
          if (!bus.start && bus.pause) begin
            state_next = S_PAUSE;
          end else if (bus.tick) begin
            if (cnt_reg == PS_LAST) begin
              cnt_next = 8'd0;
              if (digits_dec == 16'h0000) begin
                expire_evt_next = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                if (preset_clamped != 16'h0000) begin
                  digits_next = preset_clamped;
                end else begin
                  state_next  = S_EXPIRED;
                  digits_next = 16'h0000;
                end
`else
                state_next  = S_EXPIRED;
                digits_next = 16'h0000;
`endif
              end else begin
                digits_next = digits_dec;
              end
            end else begin
              cnt_next = cnt_reg + 8'd1;
            end
          end
        end
        S_PAUSE: begin
          if (bus.start)
            state_next = S_RUN;
        end
        default: begin
          state_next  = S_IDLE;
          digits_next = preset_clamped;
          cnt_next    = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      digits_reg     <= 16'h0000;
      cnt_reg        <= 8'd0;
      running_reg    <= 1'b0;
      done_reg       <= 1'b0;
      expire_evt_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      digits_reg     <= digits_next;
      cnt_reg        <= cnt_next;
      running_reg    <= (state_next == S_RUN);
      // done trails the expiry edge by one cycle; clear suppresses it.
      done_reg       <= expire_evt_reg && !bus.clear;
      expire_evt_reg <= expire_evt_next;
    end
  end

  assign bus.digits  = digits_reg;
  assign bus.running = running_reg;
  assign bus.done    = done_reg;
  assign bus.state   = state_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: one instance at PRESCALE=1, one at PRESCALE=3.
module tb_countdown_ctrl;

`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  countdown_ctrl_if if1 ();
  countdown_ctrl_if if3 ();

  countdown_ctrl #(.PRESCALE(1), .MIN_TENS_MAX(9)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1)
  );

  countdown_ctrl #(.PRESCALE(3), .MIN_TENS_MAX(9)) u_dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (if3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if1.tick = 1'b0; if1.start = 1'b0; if1.pause = 1'b0; if1.clear = 1'b0;
    if3.tick = 1'b0; if3.start = 1'b0; if3.pause = 1'b0; if3.clear = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_d;
    int v;
    errors = 0;
    checks = 0;

    // Reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if1.tick = 1'($urandom); if1.start = 1'($urandom); if1.pause = 1'($urandom);
      if1.clear = 1'($urandom); if1.preset = 16'($urandom);
      if3.tick = 1'($urandom); if3.start = 1'($urandom); if3.pause = 1'($urandom);
      if3.clear = 1'($urandom); if3.preset = 16'($urandom);
      step();
    end
    check("rst_digits", 32'(if1.digits), 32'h0000);
    check("rst_state", 32'(if1.state), 32'd0);
    check("rst_running", 32'(if1.running), 32'd0);
    check("rst_done", 32'(if1.done), 32'd0);

    reset = 1'b0;
    idle_inputs();
    if1.preset = 16'h0012;
    if3.preset = 16'h0005;
    step();
    check("idle_track", 32'(if1.digits), 32'h0012);

    // 00:12 counting down to expiry
    if1.start = 1'b1; step(); if1.start = 1'b0;
    check("load_state", 32'(if1.state), 32'd1);
    check("load_running", 32'(if1.running), 32'd1);
    check("load_digits", 32'(if1.digits), 32'h0012);
    if1.tick = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      v = 12 - i;
      exp_d = {8'h00, 4'(v / 10), 4'(v % 10)};
      if (i == 12 && AUTO) exp_d = 16'h0012;
      check($sformatf("tick%0d_digits", i), 32'(if1.digits), 32'(exp_d));
      check($sformatf("tick%0d_done", i), 32'(if1.done), 32'd0);
    end
    if1.tick = 1'b0;
    check("expire_state", 32'(if1.state), AUTO ? 32'd1 : 32'd3);
    step();
    check("done_pulse", 32'(if1.done), 32'd1);
    step();
    check("done_drop", 32'(if1.done), 32'd0);

    // 01:00 borrow chain
    if1.clear = 1'b1; step(); if1.clear = 1'b0;
    if1.preset = 16'h0100;
    if1.start = 1'b1; step(); if1.start = 1'b0;
    check("borrow_load", 32'(if1.digits), 32'h0100);
    if1.tick = 1'b1; step(); if1.tick = 1'b0;
    check("borrow_digits", 32'(if1.digits), 32'h0059);
    check("borrow_running", 32'(if1.running), 32'd1);

    // Clamping, and clear beating start
    if1.preset = 16'h9F7A;
    if1.clear = 1'b1; step(); if1.clear = 1'b0;
    check("clear_state", 32'(if1.state), 32'd0);
    check("clear_running", 32'(if1.running), 32'd0);
    check("clear_reload", 32'(if1.digits), 32'h9959);
    if1.start = 1'b1; step(); if1.start = 1'b0;
    check("clamp_digits", 32'(if1.digits), 32'h9959);
    check("clamp_state", 32'(if1.state), 32'd1);
    if1.start = 1'b1; if1.clear = 1'b1; step(); if1.start = 1'b0; if1.clear = 1'b0;
    check("startclr_state", 32'(if1.state), 32'd0);
    check("startclr_running", 32'(if1.running), 32'd0);

    // Clear on the cycle after expiry suppresses done
    if1.preset = 16'h0001;
    if1.start = 1'b1; step(); if1.start = 1'b0;
    if1.tick = 1'b1; step(); if1.tick = 1'b0;
    if1.clear = 1'b1; step(); if1.clear = 1'b0;
    check("clrdone_done", 32'(if1.done), 32'd0);
    check("clrdone_state", 32'(if1.state), 32'd0);

    // 00:00 preset expires straight from the start edge
    if1.preset = 16'h0000;
    if1.start = 1'b1; step(); if1.start = 1'b0;
    check("zero_state", 32'(if1.state), 32'd3);
    check("zero_running", 32'(if1.running), 32'd0);
    check("zero_done_early", 32'(if1.done), 32'd0);
    step();
    check("zero_done", 32'(if1.done), 32'd1);

    // PRESCALE=3 with pause/resume
    if3.start = 1'b1; step(); if3.start = 1'b0;
    if3.tick = 1'b1; step(); step(); if3.tick = 1'b0;
    check("ps3_partial", 32'(if3.digits), 32'h0005);
    if3.pause = 1'b1; step(); if3.pause = 1'b0;
    check("ps3_pause_state", 32'(if3.state), 32'd2);
    check("ps3_pause_running", 32'(if3.running), 32'd0);
    if3.tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    if3.tick = 1'b0;
    check("ps3_paused_digits", 32'(if3.digits), 32'h0005);
    if3.start = 1'b1; step(); if3.start = 1'b0;
    check("ps3_resume_state", 32'(if3.state), 32'd1);
    if3.tick = 1'b1; step(); if3.tick = 1'b0;
    check("ps3_resume_digits", 32'(if3.digits), 32'h0004);

`ifdef COUNTDOWN_AUTORELOAD_EN
    // Auto-reload: 00:02 wraps back to preset on each expiry
    if1.clear = 1'b1; if1.preset = 16'h0002; step(); if1.clear = 1'b0;
    if1.start = 1'b1; step(); if1.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if1.tick = 1'b1; step(); if1.tick = 1'b0;
      check($sformatf("ar_tick%0d_digits", i), 32'(if1.digits), (i % 2 == 1) ? 32'h0001 : 32'h0002);
      check($sformatf("ar_tick%0d_state", i), 32'(if1.state), 32'd1);
      step();
      check($sformatf("ar_tick%0d_done", i), 32'(if1.done), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
